i2s_rx: RTL and testbench

I2S receiver and slave-mode deserializer: oversamples externally driven `bclk`, `lrclk` and `sdata` in the 50 MHz system clock domain, recovers left/right PCM samples and presents them as a stereo pair with a one-cycle valid strobe. It is the capture-side counterpart of the `i2s` playback transmitter. It connects to an I2S ADC/microphone, or loops back from `i2s` on `gpio`. Downstream logic (level meter, LED/7-segment display, recorder) consumes `left`/`right` on `valid`.

---
 rtl/i2s_rx.sv | 115 +++++++++++
 tb/tb_i2s_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// i2s_rx: slave-mode I2S receiver, oversampled in the clk domain.
// Ports:
//   clk, reset_n          system clock, synchronous active-low reset
//   bclk, lrclk, sdata    asynchronous I2S pins (lrclk 0 = left slot)
//   left, right           last complete stereo pair, as received
//   valid                 one-cycle strobe when left/right update
//   locked                a well-formed frame has been seen and tracking holds
//   frame_err             one-cycle strobe when the slot just closed had the wrong length
module i2s_rx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32,
  parameter int DATA_DELAY   = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    bclk,
  input  logic                    lrclk,
  input  logic                    sdata,
  output logic [SAMPLE_WIDTH-1:0] left,
  output logic [SAMPLE_WIDTH-1:0] right,
  output logic                    valid,
  output logic                    locked,
  output logic                    frame_err
);
  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;
  localparam logic [5:0] D_LO  = 6'(DATA_DELAY);
  localparam logic [5:0] S_LEN = 6'(SAMPLE_WIDTH);
  localparam logic [5:0] SLOT  = 6'(SLOT_WIDTH);
  state_t state_q, state_d;
  logic [2:0] bclk_q;
  logic [1:0] lr_sync_q, sd_sync_q;
  logic lrclk_q, lrclk_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d, hold_q, hold_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic valid_q, valid_d, locked_q, locked_d, err_q, err_d;
  logic rise, ws, sd, ws_edge, len_ok, in_win;
  logic [5:0] idx;
  assign rise    = bclk_q[1] & ~bclk_q[2];
  assign ws      = lr_sync_q[1];
  assign sd      = sd_sync_q[1];
  assign ws_edge = rise & (ws != lrclk_q);
  assign len_ok  = bit_cnt_q == SLOT;
  assign idx     = ws_edge ? 6'd0 : bit_cnt_q;
  // Unsigned wrap makes indices below the delay fall outside the window.
  assign in_win  = (idx - D_LO) < S_LEN;
  always_comb begin
    state_d   = state_q;
    lrclk_d   = rise ? ws : lrclk_q;
    bit_cnt_d = !rise ? bit_cnt_q : ws_edge ? 6'd1 : bit_cnt_q + {5'd0, bit_cnt_q != 6'h3f};
    shift_d   = (rise && in_win) ? {shift_q[SAMPLE_WIDTH-2:0], sd} : shift_q;
    hold_d    = hold_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    locked_d  = locked_q;
    if (ws_edge) begin
      case (state_q)
        SYNC: state_d = ws ? SYNC : LEFT;
        LEFT: begin
          state_d  = len_ok ? RIGHT : SYNC;
          hold_d   = len_ok ? shift_q : hold_q;
          err_d    = !len_ok;
          locked_d = len_ok & locked_q;
        end
        RIGHT: begin
          state_d  = len_ok ? LEFT : SYNC;
          left_d   = len_ok ? hold_q : left_q;
          right_d  = len_ok ? shift_q : right_q;
          valid_d  = len_ok;
          err_d    = !len_ok;
          locked_d = len_ok;
        end
        default: state_d = SYNC;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= SYNC;
      bclk_q    <= '0;
      lr_sync_q <= '0;
      sd_sync_q <= '0;
      lrclk_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      hold_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bclk_q    <= {bclk_q[1:0], bclk};
      lr_sync_q <= {lr_sync_q[0], lrclk};
      sd_sync_q <= {sd_sync_q[0], sdata};
      lrclk_q   <= lrclk_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
    end
  end
  assign left      = left_q;
  assign right     = right_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: frame-level checking of two i2s_rx instances (left-justified and Philips) fed from one pin stream.
module tb_i2s_rx;
  localparam int SW = 16;
  logic clk = 1'b0, reset_n = 1'b0, bclk = 1'b0, lrclk = 1'b0, sdata = 1'b0;
  logic [SW-1:0] left_w[2], right_w[2];
  logic valid_w[2], locked_w[2], err_w[2];
  i2s_rx #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(32), .DATA_DELAY(0)) u_dd0 (
    .clk(clk), .reset_n(reset_n), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .left(left_w[0]), .right(right_w[0]), .valid(valid_w[0]), .locked(locked_w[0]), .frame_err(err_w[0]));
  i2s_rx #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(32), .DATA_DELAY(1)) u_dd1 (
    .clk(clk), .reset_n(reset_n), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .left(left_w[1]), .right(right_w[1]), .valid(valid_w[1]), .locked(locked_w[1]), .frame_err(err_w[1]));
  always #10 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [31:0] lw, rw; int llen, rlen; bit ev, ee;} vec_t;
  typedef struct {logic [31:0] lw, rw;} pair_t;
  vec_t tbl[12];
  pair_t exp_q[$];
  int rd[2], err_seen[2], exp_err, checks, errors;
  bit arm;
  longint fall_cyc;
  logic last_ws = 1'b0;
  logic [SW-1:0] prev_l[2], prev_r[2];
  logic prev_v[2], prev_e[2];
  // A slot is sent MSB-first as a 32-bit word; the receiver keeps SW bits starting at its data delay.
  function automatic logic [SW-1:0] cap(logic [31:0] w, int k);
    logic [31:0] t;
    t = w << k;
    return t[31:32-SW];
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_zero(string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s left%0d", tag, k), 64'(left_w[k]), 0);
      chk($sformatf("%s right%0d", tag, k), 64'(right_w[k]), 0);
      chk($sformatf("%s valid%0d", tag, k), 64'(valid_w[k]), 0);
      chk($sformatf("%s locked%0d", tag, k), 64'(locked_w[k]), 0);
      chk($sformatf("%s frame_err%0d", tag, k), 64'(err_w[k]), 0);
    end
  endtask
  task automatic chk_pending(string tag);
    for (int k = 0; k < 2; k++) chk($sformatf("%s pending%0d", tag, k), 64'(exp_q.size() - rd[k]), 0);
  endtask
  task automatic monitor();
    longint lat;
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        prev_v[k] = 1'b0;
        prev_e[k] = 1'b0;
      end else begin
        if (valid_w[k]) begin
          if (rd[k] < exp_q.size()) begin
            chk($sformatf("left%0d", k), 64'(left_w[k]), 64'(cap(exp_q[rd[k]].lw, k)));
            chk($sformatf("right%0d", k), 64'(right_w[k]), 64'(cap(exp_q[rd[k]].rw, k)));
            rd[k]++;
          end else begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid%0d: got valid=1 expected 0", k);
          end
          chk($sformatf("locked_on_valid%0d", k), 64'(locked_w[k]), 1);
          chk($sformatf("valid_width%0d", k), 64'(prev_v[k]), 0);
          lat = cyc - fall_cyc;
          checks++;
          if (lat < 3 || lat > 4) begin
            errors++;
            $display("FAIL valid_latency%0d: got %0d clk expected 3..4", k, lat);
          end
        end else begin
          chk($sformatf("hold%0d", k), {32'(left_w[k]), 32'(right_w[k])}, {32'(prev_l[k]), 32'(prev_r[k])});
        end
        if (err_w[k]) begin
          err_seen[k]++;
          chk($sformatf("locked_on_err%0d", k), 64'(locked_w[k]), 0);
          chk($sformatf("err_width%0d", k), 64'(prev_e[k]), 0);
        end
        prev_v[k] = valid_w[k];
        prev_e[k] = err_w[k];
      end
      prev_l[k] = left_w[k];
      prev_r[k] = right_w[k];
    end
  endtask
  task automatic send_bit(logic ws, logic d);
    @(negedge clk);
    bclk = 1'b0;
    lrclk = ws;
    sdata = d;
    repeat (7) @(negedge clk);
    bclk = 1'b1;
    if (last_ws && !ws) fall_cyc = cyc;
    last_ws = ws;
    repeat (7) @(negedge clk);
  endtask
  task automatic send_slot(logic ws, logic [31:0] w, int len);
    logic [31:0] s;
    s = w;
    for (int j = 0; j < len; j++) begin
      send_bit(ws, s[31]);
      s = s << 1;
    end
  endtask
  task automatic send_frame(logic [31:0] lw, logic [31:0] rw, int llen, int rlen, bit ev, bit ee);
    if (ev) exp_q.push_back('{lw, rw});
    if (ee) exp_err++;
    send_slot(1'b0, lw, llen);
    send_slot(1'b1, rw, rlen);
  endtask
  // Frame-level behaviour: a frame is captured only if it began on a recognised falling lrclk
  // while tracking (arm); a bad left slot re-arms on the very next fall, a bad right slot consumes it.
  task automatic model(int llen, int rlen, output bit ev, output bit ee);
    ev = arm && llen == 32 && rlen == 32;
    ee = arm && !ev;
    arm = !(arm && llen == 32 && rlen != 32);
  endtask
  task automatic do_reset(string tag);
    reset_n = 1'b0;
    @(negedge clk);
    chk_zero(tag);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask
  initial begin
    bit ev, ee;
    logic [31:0] lw, rw;
    int llen, rlen;
    for (int k = 0; k < 2; k++) begin
      prev_l[k] = '0;
      prev_r[k] = '0;
      prev_v[k] = 1'b0;
      prev_e[k] = 1'b0;
    end
    tbl = '{
      '{32'h1234_5678, 32'h9ABC_DEF0, 32, 32, 1'b0, 1'b0},
      '{32'h8001_0000, 32'h7FFE_0000, 32, 32, 1'b1, 1'b0},
      '{32'h52D2_8000, 32'h2D2D_0000, 32, 32, 1'b1, 1'b0},
      '{32'hFFFF_FFFF, 32'h0000_0000, 32, 31, 1'b0, 1'b1},
      '{32'hCAFE_BABE, 32'hDEAD_BEEF, 32, 32, 1'b0, 1'b0},
      '{32'h0F0F_F0F0, 32'hF0F0_0F0F, 32, 32, 1'b1, 1'b0},
      '{32'h1111_1111, 32'h2222_2222, 30, 32, 1'b0, 1'b1},
      '{32'hFFFF_0000, 32'h0000_FFFF, 32, 32, 1'b1, 1'b0},
      '{32'h3333_3333, 32'h4444_4444, 33, 32, 1'b0, 1'b1},
      '{32'h7FFF_FFFF, 32'h8000_0000, 32, 32, 1'b1, 1'b0},
      '{32'h5555_5555, 32'hAAAA_AAAA, 70, 32, 1'b0, 1'b1},
      '{32'h0001_8000, 32'hFFFE_7FFF, 32, 32, 1'b1, 1'b0}
    };
    fork
      forever begin
        @(negedge clk);
        monitor();
      end
    join_none
    repeat (4) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      model(tbl[i].llen, tbl[i].rlen, ev, ee);
      send_frame(tbl[i].lw, tbl[i].rw, tbl[i].llen, tbl[i].rlen, tbl[i].ev, tbl[i].ee);
    end
    for (int i = 0; i < 25; i++) begin
      lw = $urandom;
      rw = $urandom;
      llen = ($urandom_range(0, 5) == 0) ? $urandom_range(24, 40) : 32;
      rlen = ($urandom_range(0, 5) == 0) ? $urandom_range(24, 40) : 32;
      model(llen, rlen, ev, ee);
      send_frame(lw, rw, llen, rlen, ev, ee);
    end
    send_slot(1'b0, $urandom, 10);
    chk_pending("before_left_reset");
    do_reset("mid_left_reset");
    send_slot(1'b0, $urandom, 22);
    send_slot(1'b1, $urandom, 32);
    arm = 1'b1;
    for (int i = 0; i < 2; i++) begin
      lw = $urandom;
      rw = $urandom;
      model(32, 32, ev, ee);
      send_frame(lw, rw, 32, 32, ev, ee);
    end
    send_slot(1'b0, $urandom, 32);
    send_slot(1'b1, $urandom, 12);
    chk_pending("before_right_reset");
    do_reset("mid_right_reset");
    send_slot(1'b1, $urandom, 20);
    arm = 1'b1;
    for (int i = 0; i < 2; i++) begin
      lw = $urandom;
      rw = $urandom;
      model(32, 32, ev, ee);
      send_frame(lw, rw, 32, 32, ev, ee);
    end
    send_slot(1'b0, 32'h0, 4);
    chk_pending("final");
    for (int k = 0; k < 2; k++) chk($sformatf("frame_err_count%0d", k), 64'(err_seen[k]), 64'(exp_err));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
